// File: rtl/conv_transpose2d_s2.sv
// Streaming 2x2 / stride-2 transposed convolution.
// Accepts a HEIGHT x WIDTH signed map in raster order, buffers one row, and
// replays it twice (kernel row 0, then kernel row 1) to emit the
// 2*HEIGHT x 2*WIDTH upsampled map. Each output is pixel * tap + bias.
module conv_transpose2d_s2 #(
  parameter int HEIGHT = 14,
  parameter int WIDTH  = 14,
  parameter int DATA_W = 8,
  parameter int W_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4*W_W-1:0]         kernel_w,
  input  logic [DATA_W+W_W-1:0]    bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W+W_W:0]      out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam int OUT_W  = DATA_W + W_W + 1;
  localparam int PROD_W = DATA_W + W_W;
  localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    EMIT_EVEN = 2'd1,
    EMIT_ODD  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic                      half_q, half_d;

  logic signed [DATA_W-1:0]  linebuf_q [WIDTH];

  logic                      out_valid_q;
  logic [OUT_W-1:0]          out_data_q, out_data_d;
  logic                      out_last_q, out_last_d;

  logic                      accept;
  logic                      load;
  logic                      last_col;
  logic                      last_row;
  logic signed [W_W-1:0]     tap;
  logic signed [DATA_W-1:0]  pixel;
  logic signed [PROD_W-1:0]  product;

  assign accept   = in_valid && (state_q == FILL);
  // The output register refills whenever it is empty or being drained.
  assign load     = (state_q != FILL) && (!out_valid_q || out_ready);
  assign last_col = (col_q == COL_W'(WIDTH - 1));
  assign last_row = (row_q == ROW_W'(HEIGHT - 1));

  // Datapath: pick the tap for the current beat and form pixel * tap + bias.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    tap = '0;
    unique case ({state_q == EMIT_ODD, half_q})
      2'b00:   tap = kernel_w[0*W_W +: W_W];
      2'b01:   tap = kernel_w[1*W_W +: W_W];
      2'b10:   tap = kernel_w[2*W_W +: W_W];
      default: tap = kernel_w[3*W_W +: W_W];
    endcase
    pixel      = linebuf_q[col_q];
    product    = pixel * tap;
    out_data_d = {product[PROD_W-1], product} + {bias[PROD_W-1], bias};
    out_last_d = (state_q == EMIT_ODD) && half_q && last_col && last_row;
  end

  // Next-state logic for the row fill / two-pass replay sequencer.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    half_d  = half_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (last_col) begin
            col_d   = '0;
            state_d = EMIT_EVEN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      EMIT_EVEN, EMIT_ODD: begin
        if (load) begin
          half_d = ~half_q;
          if (half_q) begin
            if (last_col) begin
              col_d = '0;
              if (state_q == EMIT_EVEN) begin
                state_d = EMIT_ODD;
              end else begin
                state_d = FILL;
                row_d   = last_row ? '0 : row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Sequencer state and counters.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      half_q  <= half_d;
    end
  end

  // Line buffer: one input row, written during FILL.
  always_ff @(posedge clk) begin
    // NOTE: storage array is deliberately not reset; its contents are only
    // read after being rewritten by a full row.
    if (accept) begin
      linebuf_q[col_q] <= in_data;
    end
  end

  // Output register: load a new beat, or drop valid once the beat is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != FILL) || (col_q != '0) || (row_q != '0) || out_valid_q;

endmodule

// File: tb/tb_conv_transpose2d_s2.sv
// Bench for conv_transpose2d_s2 on a 2x2 map. A frame-level model expands
// each input frame into its upsampled output sequence; a cycle loop drives
// random handshakes and checks output beats, hold stability and in_ready.
module tb_conv_transpose2d_s2;

  localparam int H  = 2;
  localparam int W  = 2;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int OW = DW + WW + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4*WW-1:0] kernel_w = '0;
  logic [DW+WW-1:0] bias = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OW-1:0]   out_data;
  logic            out_last;
  logic            busy;

  conv_transpose2d_s2 #(.HEIGHT(H), .WIDTH(W), .DATA_W(DW), .W_W(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .kernel_w  (kernel_w),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
  } beat_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    k_tap [4];
  int    bias_v;
  int    frame_px [H][W];
  int    pix_q [$];
  beat_t exp_q [$];

  task automatic set_params(input int k00, input int k01, input int k10,
                            input int k11, input int b);
    k_tap[0] = k00; k_tap[1] = k01; k_tap[2] = k10; k_tap[3] = k11;
    bias_v   = b;
    kernel_w = {WW'(k11), WW'(k10), WW'(k01), WW'(k00)};
    bias     = (DW+WW)'(b);
  endtask

  // Reference: row r, kernel row kr, column c, kernel column kc gives
  // output pixel (2r+kr, 2c+kc) = in[r][c] * k[kr][kc] + bias.
  task automatic queue_frame();
    beat_t b;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix_q.push_back(frame_px[r][c]);
    for (int r = 0; r < H; r++)
      for (int kr = 0; kr < 2; kr++)
        for (int c = 0; c < W; c++)
          for (int kc = 0; kc < 2; kc++) begin
            b.data = frame_px[r][c] * k_tap[kr*2 + kc] + bias_v;
            b.last = (r == H-1) && (kr == 1) && (c == W-1) && (kc == 1);
            exp_q.push_back(b);
          end
  endtask

  task automatic random_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame_px[r][c] = int'($urandom_range(0, 255)) - 128;
    queue_frame();
  endtask

  // Cycle loop: inputs change at the falling edge, transfers happen at the
  // following rising edge. in_ready must be high exactly when every row
  // accepted so far has had all but its final beat taken.
  task automatic run_traffic(input int in_pct, input int out_pct,
                             input int stop_after, input bit stall_last,
                             input string tag, output int first_gap,
                             output bit saw_ready_last);
    int          cyc = 0;
    int          in_acc = 0;
    int          out_acc = 0;
    int          row_last_acc = -1;
    int          first_valid = -1;
    int          rows_done;
    int          stall_cnt = 0;
    bit          exp_rdy;
    bit          prev_stall = 0;
    logic [OW-1:0] prev_data = '0;
    logic        prev_last = 1'b0;
    beat_t       e;
    saw_ready_last = 0;
    while (exp_q.size() > 0 && !(stop_after > 0 && out_acc >= stop_after)) begin
      @(negedge clk);
      if (cyc >= 3000) begin
        n_cmp++; n_bad++;
        $display("FAIL %s timeout: %0d beats still outstanding, want 0", tag, exp_q.size());
        break;
      end
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          n_bad++;
          $display("FAIL %s hold: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                   tag, out_valid, $signed(out_data), out_last, $signed(prev_data), prev_last);
        end
      end
      rows_done = in_acc / W;
      exp_rdy   = (rows_done == 0) || (out_acc >= rows_done*4*W - 1);
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_bad++;
        $display("FAIL %s in_ready cyc %0d: got %b want %b", tag, cyc, in_ready, exp_rdy);
      end
      in_valid = (pix_q.size() > 0) && (int'($urandom_range(0, 99)) < in_pct);
      in_data  = (pix_q.size() > 0) ? DW'(pix_q[0]) : DW'($urandom);
      if (stall_last && out_valid && out_last && stall_cnt < 3) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = (int'($urandom_range(0, 99)) < out_pct);
        if (!(out_valid && out_last)) stall_cnt = 0;
      end
      #1;
      if (out_valid && out_last && !out_ready && in_ready) saw_ready_last = 1;
      if (in_valid && in_ready) begin
        void'(pix_q.pop_front());
        in_acc++;
        if (in_acc == W && row_last_acc < 0) row_last_acc = cyc;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s extra beat: got %0d want none", tag, $signed(out_data));
        end else begin
          e = exp_q.pop_front();
          if (int'($signed(out_data)) !== e.data || out_last !== e.last) begin
            n_bad++;
            $display("FAIL %s beat %0d: got d=%0d l=%b want d=%0d l=%b",
                     tag, out_acc, $signed(out_data), out_last, e.data, e.last);
          end
        end
        out_acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      cyc++;
    end
    first_gap = first_valid - row_last_acc;
    if (stop_after == 0) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL %s idle: got busy=%b v=%b rdy=%b want 0 0 1", tag, busy, out_valid, in_ready);
      end
    end
  endtask

  task automatic check_idle_after_reset(input string tag);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
        in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got v=%b d=%0d l=%b rdy=%b busy=%b want 0 0 0 1 0",
               tag, out_valid, $signed(out_data), out_last, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_data   = DW'($urandom);
      out_ready = 1'($urandom);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check_idle_after_reset("reset");
  endtask

  task automatic test_functional();
    int gap;
    bit saw;
    set_params(1, 2, 3, 4, 0);
    frame_px = '{'{5, -1}, '{2, 3}};
    queue_frame();
    run_traffic(100, 100, 0, 0, "functional", gap, saw);
    n_cmp++;
    if (gap !== 2) begin
      n_bad++;
      $display("FAIL functional latency: got %0d cycles want 2", gap);
    end
  endtask

  task automatic test_extremes();
    int gap;
    bit saw;
    set_params(-128, -128, -128, -128, 32767);
    frame_px = '{'{-128, -128}, '{-128, -128}};
    queue_frame();
    run_traffic(100, 100, 0, 0, "extremes", gap, saw);
  endtask

  task automatic test_backpressure();
    int gap;
    bit saw;
    set_params(1, 2, 3, 4, 0);
    frame_px = '{'{5, -1}, '{2, 3}};
    queue_frame();
    run_traffic(100, 50, 0, 0, "backpressure", gap, saw);
  endtask

  task automatic test_input_gating();
    int gap;
    bit saw;
    set_params(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 65535)) - 32768);
    random_frame();
    random_frame();
    run_traffic(100, 70, 0, 1, "gating", gap, saw);
    n_cmp++;
    if (saw !== 1'b1) begin
      n_bad++;
      $display("FAIL gating ready_during_last_stall: got %b want 1", saw);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    bit saw;
    set_params(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 65535)) - 32768);
    for (int f = 0; f < 3; f++) random_frame();
    run_traffic(80, 80, 0, 0, "back_to_back", gap, saw);
  endtask

  task automatic test_mid_frame_reset();
    int gap;
    bit saw;
    set_params(3, -7, 11, -2, 100);
    random_frame();
    run_traffic(100, 100, 3, 0, "pre_reset", gap, saw);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    #1;
    check_idle_after_reset("mid_reset");
    pix_q.delete();
    exp_q.delete();
    random_frame();
    run_traffic(90, 60, 0, 0, "post_reset", gap, saw);
  endtask

  initial begin
    test_reset();
    test_functional();
    test_extremes();
    test_backpressure();
    test_input_gating();
    test_back_to_back();
    test_mid_frame_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
